// File: rtl/menu_screen_fsm.sv
// menu_screen_fsm: game UI screen controller driven by hit-tested mouse clicks
// Owns the one-hot screen state, the latched level and the timed game-logic reset pulse.
module menu_screen_fsm #(
  parameter int NUM_BUTTONS    = 3,
  parameter int BTN_X          = 412,
  parameter int BTN_W          = 200,
  parameter int BTN_H          = 60,
  parameter int BTN_Y0         = 300,
  parameter int BTN_PITCH      = 100,
  parameter int RST_PULSE      = 4,
  parameter int TIMEOUT_CYCLES = 65000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mouse_left,
  input  logic                           mouse_right,
  input  logic [11:0]                    xpos,
  input  logic [11:0]                    ypos,
  input  logic                           game_over,
  output logic [3:0]                     screen,
  output logic [$clog2(NUM_BUTTONS)-1:0] level,
  output logic                           rst_sys
);
  localparam int LW = $clog2(NUM_BUTTONS);
  localparam int PW = $clog2(RST_PULSE + 1);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0] S_START  = 4'b0001;
  localparam logic [3:0] S_SELECT = 4'b0010;
  localparam logic [3:0] S_GAME   = 4'b0100;
  localparam logic [3:0] S_END    = 4'b1000;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW-1:0] P_LEN  = PW'(RST_PULSE);
  logic [3:0]             r_state;
  logic [LW-1:0]          r_level;
  logic [PW-1:0]          r_pcnt;
  logic [CW-1:0]          r_cnt;
  logic                   r_left_q;
  logic                   r_right_q;
  logic                   w_lclick;
  logic                   w_rclick;
  logic [12:0]            w_x;
  logic [12:0]            w_y;
  logic [NUM_BUTTONS-1:0] w_hit;
  logic [LW-1:0]          w_hit_idx;
  logic                   w_timeout;
  logic                   w_req;
  logic [3:0]             w_next;
  assign w_lclick = mouse_left & ~r_left_q;
  assign w_rclick = mouse_right & ~r_right_q;
  assign w_x      = {1'b0, xpos};
  assign w_y      = {1'b0, ypos};
  for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_hit
    localparam logic [12:0] Y_TOP = 13'(BTN_Y0 + k * BTN_PITCH);
    localparam logic [12:0] Y_BOT = 13'(BTN_Y0 + k * BTN_PITCH + BTN_H);
    assign w_hit[k] = w_x >= 13'(BTN_X) && w_x <= 13'(BTN_X + BTN_W) && w_y >= Y_TOP && w_y <= Y_BOT;
  end
  // Scan downwards so the lowest-index hit is the one that survives
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--)
      if (w_hit[i]) w_hit_idx = LW'(i);
  end
  assign w_timeout = (TIMEOUT_CYCLES > 0) && r_cnt == T_LAST && !w_lclick;
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      S_START:  w_next = w_lclick && w_hit[0] ? S_SELECT : S_START;
      S_SELECT: begin
        w_next = w_rclick ? S_START : w_lclick && |w_hit ? S_GAME : S_SELECT;
        w_req  = !w_rclick && w_lclick && |w_hit;
      end
      S_GAME:   w_next = w_rclick || game_over ? S_END : S_GAME;
      S_END: begin
        w_next = w_lclick && w_hit[0] ? S_SELECT :
                 w_lclick && w_hit[1] ? S_START :
                 w_timeout            ? S_START : S_END;
        w_req  = w_lclick && w_hit[0];
      end
      default:  w_next = S_START;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_START;
      r_level   <= '0;
      r_pcnt    <= '0;
      r_cnt     <= '0;
      r_left_q  <= 1'b1;
      r_right_q <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_level   <= w_req && r_state == S_SELECT ? w_hit_idx : r_level;
      r_pcnt    <= w_req ? P_LEN : r_pcnt != '0 ? r_pcnt - 1'b1 : '0;
      r_cnt     <= r_state == S_END && w_next == S_END && !w_lclick && !w_rclick ? r_cnt + 1'b1 : '0;
      r_left_q  <= mouse_left;
      r_right_q <= mouse_right;
    end
  end
  assign screen  = r_state;
  assign level   = r_level;
  assign rst_sys = r_pcnt != '0;
endmodule

// File: tb/tb_menu_screen_fsm.sv
// tb_menu_screen_fsm: directed scenarios plus random clicks against a screen-rule model
// Two instances share stimulus: timeout 16 and timeout disabled.
module tb_menu_screen_fsm;
  logic        clk, rst, ml, mr, go;
  logic [11:0] x, y;
  logic [3:0]  scr1, scr0;
  logic [1:0]  lvl1, lvl0;
  logic        rs1, rs0;
  int checks = 0, errors = 0;
  int m_scr[2], m_lv[2], m_pl[2], m_idle[2];
  bit m_lq[2], m_rq[2];

  menu_screen_fsm #(.TIMEOUT_CYCLES(16)) dut1 (.clk(clk), .rst(rst), .mouse_left(ml), .mouse_right(mr),
    .xpos(x), .ypos(y), .game_over(go), .screen(scr1), .level(lvl1), .rst_sys(rs1));
  menu_screen_fsm #(.TIMEOUT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .mouse_left(ml), .mouse_right(mr),
    .xpos(x), .ypos(y), .game_over(go), .screen(scr0), .level(lvl0), .rst_sys(rs0));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int hit_of(int px, int py);
    for (int k = 0; k < 3; k++)
      if (px >= 412 && px <= 612 && py >= 300 + 100 * k && py <= 360 + 100 * k) return k;
    return -1;
  endfunction

  // Screens as indices 0..3 (START, SELECT, GAME, END); instance i has timeout tmo
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int tmo, h, nxt;
      bit lc, rc, req;
      tmo = i == 0 ? 0 : 16;
      if (rst) begin
        m_scr[i] = 0; m_lv[i] = 0; m_pl[i] = 0; m_idle[i] = 0; m_lq[i] = 1; m_rq[i] = 1;
      end else begin
        lc = ml && !m_lq[i];
        rc = mr && !m_rq[i];
        h = hit_of(int'(x), int'(y));
        nxt = m_scr[i];
        req = 0;
        if (m_scr[i] == 0 && lc && h == 0) nxt = 1;
        if (m_scr[i] == 1) begin
          if (rc) nxt = 0;
          else if (lc && h >= 0) begin nxt = 2; req = 1; m_lv[i] = h; end
        end
        if (m_scr[i] == 2 && (rc || go)) nxt = 3;
        if (m_scr[i] == 3) begin
          if (lc && h == 0) begin nxt = 1; req = 1; end
          else if (lc && h == 1) nxt = 0;
          else if (tmo > 0 && !lc && m_idle[i] == tmo - 1) nxt = 0;
        end
        m_idle[i] = (m_scr[i] == 3 && nxt == 3 && !lc && !rc) ? m_idle[i] + 1 : 0;
        m_pl[i] = req ? 4 : (m_pl[i] > 0 ? m_pl[i] - 1 : 0);
        m_scr[i] = nxt;
        m_lq[i] = ml;
        m_rq[i] = mr;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(int px, int py, bit l, bit r);
    ml = 0; mr = 0;
    cyc();
    x = 12'(px); y = 12'(py); ml = l; mr = r;
    cyc();
    ml = 0; mr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic go_select();
    do_reset();
    press(500, 320, 1, 0);
  endtask

  task automatic go_end();
    go_select();
    press(500, 320, 1, 0);
    go = 1; cyc(); go = 0;
  endtask

  task automatic test_reset();
    ml = 1; x = 500; y = 320;
    do_reset();
    checks++;
    if (scr1 !== 4'b0001 || lvl1 !== 2'd0 || rs1 !== 1'b0) begin
      errors++; $display("FAIL reset_values screen=%b level=%0d rst_sys=%b want 0001/0/0", scr1, lvl1, rs1);
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (scr1 !== 4'b0001) begin errors++; $display("FAIL held_through_reset cyc %0d screen=%b want 0001", i, scr1); end
    end
    ml = 0;
  endtask

  task automatic test_start();
    do_reset();
    press(500, 361, 1, 0);
    checks++;
    if (scr1 !== 4'b0001) begin errors++; $display("FAIL start_below_edge screen=%b want 0001", scr1); end
    press(613, 320, 1, 0);
    checks++;
    if (scr1 !== 4'b0001) begin errors++; $display("FAIL start_right_edge screen=%b want 0001", scr1); end
    press(612, 360, 1, 0);
    checks++;
    if (scr1 !== 4'b0010) begin errors++; $display("FAIL start_corner_inclusive screen=%b want 0010", scr1); end
    do_reset();
    press(500, 320, 1, 0);
    checks++;
    if (scr1 !== 4'b0010) begin errors++; $display("FAIL start_to_select screen=%b want 0010", scr1); end
  endtask

  task automatic test_select();
    go_select();
    press(412, 500, 1, 0);
    checks++;
    if (scr1 !== 4'b0100 || lvl1 !== 2'd2 || rs1 !== 1'b1) begin
      errors++; $display("FAIL select_btn2 screen=%b level=%0d rst_sys=%b want 0100/2/1", scr1, lvl1, rs1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (rs1 !== 1'b1) begin errors++; $display("FAIL pulse_body cyc %0d rst_sys=%b want 1", i + 2, rs1); end
    end
    cyc();
    checks++;
    if (rs1 !== 1'b0) begin errors++; $display("FAIL pulse_end rst_sys=%b want 0", rs1); end
    go = 1; cyc(); go = 0;
    checks++;
    if (scr1 !== 4'b1000 || lvl1 !== 2'd2) begin errors++; $display("FAIL game_over screen=%b level=%0d want 1000/2", scr1, lvl1); end
    press(500, 320, 1, 0);
    checks++;
    if (scr1 !== 4'b0010) begin errors++; $display("FAIL end_to_select screen=%b want 0010", scr1); end
    press(500, 320, 1, 1);
    checks++;
    if (scr1 !== 4'b0001) begin errors++; $display("FAIL rclick_priority screen=%b want 0001", scr1); end
  endtask

  task automatic test_back_to_back();
    go_select();
    press(500, 420, 1, 0);
    checks++;
    if (scr1 !== 4'b0100 || lvl1 !== 2'd1) begin errors++; $display("FAIL select_btn1 screen=%b level=%0d want 0100/1", scr1, lvl1); end
    repeat (5) cyc();
    press(500, 500, 0, 1);
    checks++;
    if (scr1 !== 4'b1000 || lvl1 !== 2'd1 || rs1 !== 1'b0) begin
      errors++; $display("FAIL game_rclick screen=%b level=%0d rst_sys=%b want 1000/1/0", scr1, lvl1, rs1);
    end
    press(500, 320, 1, 0);
    checks++;
    if (scr1 !== 4'b0010 || rs1 !== 1'b1) begin errors++; $display("FAIL b2b_first screen=%b rst_sys=%b want 0010/1", scr1, rs1); end
    cyc();
    checks++;
    if (rs1 !== 1'b1) begin errors++; $display("FAIL b2b_c2 rst_sys=%b want 1", rs1); end
    ml = 1; cyc(); ml = 0;
    checks++;
    if (scr1 !== 4'b0100 || lvl1 !== 2'd0 || rs1 !== 1'b1) begin
      errors++; $display("FAIL b2b_second screen=%b level=%0d rst_sys=%b want 0100/0/1", scr1, lvl1, rs1);
    end
    for (int i = 4; i <= 6; i++) begin
      cyc();
      checks++;
      if (rs1 !== 1'b1) begin errors++; $display("FAIL b2b_restart c+%0d rst_sys=%b want 1", i, rs1); end
    end
    cyc();
    checks++;
    if (rs1 !== 1'b0) begin errors++; $display("FAIL b2b_end rst_sys=%b want 0", rs1); end
  endtask

  task automatic test_timeout();
    go_end();
    for (int i = 1; i <= 15; i++) begin
      cyc();
      checks++;
      if (scr1 !== 4'b1000) begin errors++; $display("FAIL idle e+%0d screen=%b want 1000", i, scr1); end
    end
    cyc();
    checks++;
    if (scr1 !== 4'b0001) begin errors++; $display("FAIL timeout_fire screen=%b want 0001", scr1); end
    go_end();
    repeat (9) cyc();
    mr = 1; cyc(); mr = 0;
    for (int i = 12; i <= 26; i++) begin
      cyc();
      checks++;
      if (scr1 !== 4'b1000) begin errors++; $display("FAIL postponed e+%0d screen=%b want 1000", i, scr1); end
    end
    cyc();
    checks++;
    if (scr1 !== 4'b0001) begin errors++; $display("FAIL postponed_fire screen=%b want 0001", scr1); end
    checks++;
    if (scr0 !== 4'b1000) begin errors++; $display("FAIL no_timeout screen=%b want 1000", scr0); end
  endtask

  task automatic test_rst_pulse();
    go_select();
    press(500, 500, 1, 0);
    cyc();
    rst = 1; cyc(); rst = 0;
    checks++;
    if (scr1 !== 4'b0001 || lvl1 !== 2'd0 || rs1 !== 1'b0) begin
      errors++; $display("FAIL rst_in_pulse screen=%b level=%0d rst_sys=%b want 0001/0/0", scr1, lvl1, rs1);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) ml = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) mr = 1'($urandom_range(0, 1));
      x = 12'($urandom_range(400, 625));
      y = 12'($urandom_range(290, 570));
      go = $urandom_range(0, 30) == 0;
      rst = $urandom_range(0, 700) == 0;
      cyc();
      checks++;
      if (scr1 !== 4'(1 << m_scr[1]) || lvl1 !== 2'(m_lv[1]) || rs1 !== (m_pl[1] > 0)) begin
        errors++;
        if (shown++ < 10) $display("FAIL random_t16 n=%0d screen=%b level=%0d rst_sys=%b want %b/%0d/%0d",
          n, scr1, lvl1, rs1, 4'(1 << m_scr[1]), m_lv[1], m_pl[1] > 0);
      end
      checks++;
      if (scr0 !== 4'(1 << m_scr[0]) || lvl0 !== 2'(m_lv[0]) || rs0 !== (m_pl[0] > 0)) begin
        errors++;
        if (shown++ < 10) $display("FAIL random_t0 n=%0d screen=%b level=%0d rst_sys=%b want %b/%0d/%0d",
          n, scr0, lvl0, rs0, 4'(1 << m_scr[0]), m_lv[0], m_pl[0] > 0);
      end
    end
    rst = 0; ml = 0; mr = 0; go = 0;
  endtask

  initial begin
    rst = 1; ml = 0; mr = 0; go = 0; x = 0; y = 0;
    test_reset();
    test_start();
    test_select();
    test_back_to_back();
    test_timeout();
    test_rst_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/menu_screen_fsm.md
Name: menu_screen_fsm

Overview:
- Parametrised screen controller for the game UI. Tracks the current screen (start, level select, game, end) from mouse clicks hit-tested against a column of NUM_BUTTONS rectangular buttons.
- Drives the one-hot screen code consumed by the draw pipeline, plus the selected level and a timed system-reset pulse.
- Sits between the mouse controller (xpos/ypos/buttons) and the screen-draw and game-logic blocks.
- Adds to the previous generation: click edge detection, N-button hit test, level latch, multi-cycle reset pulse, game_over input, and idle timeout.

Parameters:
- NUM_BUTTONS, 3: buttons in the column, minimum 2; button k is at y = BTN_Y0 + k*BTN_PITCH.
- BTN_X, 412: left edge of every button, in pixels.
- BTN_W, 200: button width, in pixels.
- BTN_H, 60: button height, in pixels.
- BTN_Y0, 300: top edge of button 0, in pixels.
- BTN_PITCH, 100: vertical distance between button tops; must be greater than BTN_H.
- RST_PULSE, 4: rst_sys pulse length in clk cycles, minimum 1.
- TIMEOUT_CYCLES, 65000000: END-screen idle cycles before automatic return to START; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- mouse_left  in  1  left button level.
- mouse_right  in  1  right button level.
- xpos  in  12  cursor x, in pixels.
- ypos  in  12  cursor y, in pixels.
- game_over  in  1  level pulse from game logic.
- screen  out  4  one-hot screen: [0]=START, [1]=SELECT, [2]=GAME, [3]=END.
- level  out  $clog2(NUM_BUTTONS)  level latched in SELECT.
- rst_sys  out  1  game-logic reset pulse.

Behaviour:
- Reset values: screen=4'b0001, level=0, rst_sys=0, timeout counter=0, left_q=1, right_q=1.
  - left_q/right_q reset to 1, so a button held through reset does not count as a click.
- Edge detection:
  - left_q and right_q register the previous button levels.
  - lclick = mouse_left & ~left_q.
  - rclick = mouse_right & ~right_q.
  - Holding a button produces exactly one click, so no release-wait states are needed.
- Hit test (combinational, on the current xpos/ypos):
  - hit[k] = (BTN_X <= xpos <= BTN_X+BTN_W) && (Y_k <= ypos <= Y_k+BTN_H), bounds inclusive, Y_k = BTN_Y0 + k*BTN_PITCH.
  - Compute in 13-bit unsigned so sums do not wrap.
  - Lowest-index hit wins if regions overlap.
- Latency: a click sampled at cycle t updates screen, level and rst_sys in the registers at the end of cycle t, visible at t+1.
- screen always reflects the current state, with no one-cycle lag.
- Transitions (any condition not listed holds the current state):
  - START: lclick & hit[0] -> SELECT.
  - SELECT, with rclick taking priority over lclick in the same cycle:
    - rclick -> START.
    - otherwise lclick & hit[k] for any k -> GAME, level<=k, start rst_sys pulse.
  - GAME: rclick | game_over -> END. level and rst_sys are unchanged.
  - END, with lclick taking priority over timeout in the same cycle:
    - lclick & hit[0] -> SELECT, start rst_sys pulse.
    - lclick & hit[1] -> START.
    - timeout -> START.
- Timeout counter (active only when TIMEOUT_CYCLES>0):
  - Cleared on entering END and on any lclick/rclick while in END.
  - Increments each cycle in END; held at 0 outside END.
  - When the counter equals TIMEOUT_CYCLES-1, the next state is START.
- rst_sys pulse:
  - Starting a pulse sets rst_sys=1 for exactly RST_PULSE consecutive cycles, beginning the cycle screen changes.
  - A new pulse request during an active pulse restarts the count to the full RST_PULSE.
  - rst during a pulse ends it immediately (rst_sys=0 the next cycle).
- level changes only on the SELECT->GAME transition and holds in every other state.
- Unreachable state encodings recover to START on the next cycle.

Test Plan:
- Reset while mouse_left=1, then hold for 10 cycles -> screen stays 4'b0001 (no click generated).
- START click at (500,320) -> screen=4'b0010 the next cycle. Repeat with a click at (500,361) or (613,320) -> screen unchanged (just outside the bounds).
- SELECT click at (412,500), button 2 top-left corner -> screen=4'b0100, level=2, rst_sys high for exactly 4 cycles. In the same scenario, lclick and rclick in the same cycle -> screen=4'b0001.
- GAME with a game_over pulse -> END. In END, click button 0 at cycle c, then again at c+2 -> rst_sys high continuously from c+1 through c+6, and screen=SELECT then GAME.
- END idle with TIMEOUT_CYCLES=16 -> screen=4'b0001 exactly 16 cycles after entry. An rclick at cycle 10 postpones the return to cycle 27 (counter cleared at 10, reaches 15 at 26, START visible at 27). With TIMEOUT_CYCLES=0 -> END holds indefinitely.
- rst asserted during the 2nd cycle of an rst_sys pulse in GAME -> the next cycle shows screen=4'b0001, level=0, rst_sys=0.
